// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared pixel types, FSM states and default 12 MHz WS2812 timing.
package ws2812_pkg;
    localparam int NUM_LEDS_DEF  = 7;
    localparam int T0H_CYC_DEF   = 4;
    localparam int T1H_CYC_DEF   = 8;
    localparam int TBIT_CYC_DEF  = 15;
    localparam int LATCH_CYC_DEF = 3600;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} ws_state_e;

    function automatic logic [23:0] grb_order(rgb_t p);
        return {p.g, p.r, p.b};
    endfunction
endpackage

// File: rtl/ws2812_frame_sched_if.sv
// ws2812_frame_sched_if: pixel bus, frame handshake and ws line; adds bright when WS_BRIGHTNESS_EN is defined.
interface ws2812_frame_sched_if #(parameter int NUM_LEDS = 7);
    logic [24*NUM_LEDS-1:0] rgb_flat;
    logic                   frame_req;
    logic                   busy;
    logic                   frame_done;
    logic                   ws;
`ifdef WS_BRIGHTNESS_EN
    logic [2:0]             bright;
    modport master (output rgb_flat, frame_req, bright, input busy, frame_done, ws);
    modport slave (input rgb_flat, frame_req, bright, output busy, frame_done, ws);
`else
    modport master (output rgb_flat, frame_req, input busy, frame_done, ws);
    modport slave (input rgb_flat, frame_req, output busy, frame_done, ws);
`endif
endinterface

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: per-bit HIGH/LOW timing counter, flags end of high phase and end of bit.
module ws2812_bit_tx #(
    parameter int T0H_CYC  = 4,
    parameter int T1H_CYC  = 8,
    parameter int TBIT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_valid_i,
    input  logic bit_val_i,
    output logic hi_done_o,
    output logic bit_done_o
);
    localparam int CW = $clog2(TBIT_CYC);

    logic [CW-1:0] cnt_q, cnt_d, th_m1;

    always_comb begin
        th_m1      = bit_val_i ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);
        hi_done_o  = bit_valid_i && cnt_q == th_m1;
        bit_done_o = bit_valid_i && cnt_q == CW'(TBIT_CYC - 1);
        cnt_d      = bit_valid_i && !bit_done_o ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched: snapshots NUM_LEDS pixels and sends one GRB WS2812 frame plus latch gap.
// WS_BRIGHTNESS_EN adds a 3-bit per-frame right shift of every channel.
module ws2812_frame_sched
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS  = NUM_LEDS_DEF,
    parameter int T0H_CYC   = T0H_CYC_DEF,
    parameter int T1H_CYC   = T1H_CYC_DEF,
    parameter int TBIT_CYC  = TBIT_CYC_DEF,
    parameter int LATCH_CYC = LATCH_CYC_DEF
) (
    input logic                 clk,
    input logic                 rst,
    ws2812_frame_sched_if.slave bus
);
    localparam int PW = $clog2(NUM_LEDS > 1 ? NUM_LEDS : 2);
    localparam int LW = $clog2(LATCH_CYC > 1 ? LATCH_CYC : 2);

    ws_state_e     state_q, state_d;
    rgb_t          shadow_q [NUM_LEDS];
    rgb_t          snap_d [NUM_LEDS];
    logic [PW-1:0] pix_q, pix_d;
    logic [4:0]    bit_q, bit_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          pend_q, pend_d, ws_q, ws_d, done_q, done_d;
    logic          start, last_bit, adv, lat_end, hi_done, bit_done;
    logic [23:0]   cur_word;

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            snap_d[i] = bus.rgb_flat[24*i +: 24];
`ifdef WS_BRIGHTNESS_EN
            snap_d[i].r = snap_d[i].r >> bus.bright;
            snap_d[i].g = snap_d[i].g >> bus.bright;
            snap_d[i].b = snap_d[i].b >> bus.bright;
`endif
        end
    end

    assign cur_word = grb_order(shadow_q[pix_q]);
    assign start    = state_q == IDLE && (bus.frame_req || pend_q);
    assign last_bit = pix_q == PW'(NUM_LEDS - 1) && bit_q == '0;
    assign adv      = state_q == LOW && bit_done && !last_bit;
    assign lat_end  = lat_q == LW'(LATCH_CYC - 1);

    ws2812_bit_tx #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .TBIT_CYC(TBIT_CYC)
    ) u_bit_tx (
        .clk        (clk),
        .rst        (rst),
        .bit_valid_i(state_q == HIGH || state_q == LOW),
        .bit_val_i  (cur_word[bit_q]),
        .hi_done_o  (hi_done),
        .bit_done_o (bit_done)
    );

    always_comb begin
        state_d = state_q == IDLE ? (start ? HIGH : IDLE)
                : state_q == HIGH ? (hi_done ? LOW : HIGH)
                : state_q == LOW  ? (bit_done ? (last_bit ? LATCH : HIGH) : LOW)
                : (lat_end ? IDLE : LATCH);
        // requests seen while a frame is running collapse into one pending frame
        pend_d  = !start && (pend_q || (bus.frame_req && state_q != IDLE));
        pix_d   = start ? '0 : adv && bit_q == '0 ? pix_q + 1'b1 : pix_q;
        bit_d   = start ? 5'd23 : adv ? (bit_q == '0 ? 5'd23 : bit_q - 1'b1) : bit_q;
        lat_d   = state_q == LATCH && !lat_end ? lat_q + 1'b1 : '0;
    end

    always_comb begin
        ws_d   = state_d == HIGH;
        done_d = state_q == LATCH && lat_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pix_q   <= '0;
            bit_q   <= '0;
            lat_q   <= '0;
            pend_q  <= 1'b0;
            ws_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            bit_q   <= bit_d;
            lat_q   <= lat_d;
            pend_q  <= pend_d;
            ws_q    <= ws_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (start) shadow_q <= snap_d;
    end

    assign bus.ws         = ws_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_ws2812_frame_sched.sv
// tb_ws2812_frame_sched: decodes the ws line and checks whole frames against a GRB/brightness model.
module tb_ws2812_frame_sched;
    localparam int NL = 7, T0H = 4, T1H = 8, TBIT = 15, FRAME = NL * 24 * TBIT + 3600;

    logic clk = 1'b0, rst = 1'b1;
    int   n_chk = 0, n_pass = 0, cyc = 0, hi_len = 0;
    logic ws_prev = 1'b0;
    int   rise_cyc[$], done_cyc[$], his[$];
    bit   bits[$];
    logic [23:0] exp_px [NL];
    logic [23:0] dec_px [NL];
    int   exp_br = 0;

    ws2812_frame_sched_if #(.NUM_LEDS(NL)) bus();

    ws2812_frame_sched #(.NUM_LEDS(NL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ws && !ws_prev) rise_cyc.push_back(cyc);
        if (!bus.ws && ws_prev) begin
            bits.push_back(hi_len == T1H);
            his.push_back(hi_len);
        end
        if (bus.frame_done) done_cyc.push_back(cyc);
        hi_len  = bus.ws ? hi_len + 1 : 0;
        ws_prev = bus.ws;
    end

    function automatic logic [23:0] model_grb(logic [23:0] px, int br);
        logic [7:0] r, g, b;
        r = px[23:16] >> br;
        g = px[15:8] >> br;
        b = px[7:0] >> br;
        return {g, r, b};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rise_cyc.delete();
        done_cyc.delete();
        his.delete();
        bits.delete();
    endtask

    task automatic request(string tag);
        for (int i = 0; i < NL; i++) exp_px[i] = bus.rgb_flat[24*i +: 24];
`ifdef WS_BRIGHTNESS_EN
        exp_br = int'(bus.bright);
`endif
        check({tag, "_ws_before"}, 32'(bus.ws), 0);
        bus.frame_req = 1'b1;
        step(1);
        bus.frame_req = 1'b0;
        check({tag, "_ws_rise"}, 32'(bus.ws), 1);
        check({tag, "_busy_rise"}, 32'(bus.busy), 1);
    endtask

    task automatic wait_frame(string tag);
        int n = 0;
        while (done_cyc.size() == 0 && n < 2 * FRAME) begin
            step(1);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cyc.size()), 1);
    endtask

    task automatic check_frame(string tag);
        int bad = 0;
        check({tag, "_done_pulse"}, 32'(bus.frame_done), 1);
        check({tag, "_busy_fall"}, 32'(bus.busy), 0);
        check({tag, "_nbits"}, 32'(bits.size()), NL * 24);
        for (int p = 0; p < NL; p++) begin
            dec_px[p] = '0;
            for (int j = 0; j < 24 && 24 * p + j < bits.size(); j++)
                dec_px[p] = {dec_px[p][22:0], bits[24*p+j]};
            check($sformatf("%s_px%0d", tag, p), 32'(dec_px[p]), 32'(model_grb(exp_px[p], exp_br)));
        end
        for (int k = 0; k + 1 < rise_cyc.size(); k++) if (rise_cyc[k+1] - rise_cyc[k] != TBIT) bad++;
        foreach (his[k]) if (his[k] != T0H && his[k] != T1H) bad++;
        check({tag, "_bit_timing"}, 32'(bad), 0);
        if (rise_cyc.size() > 0 && done_cyc.size() > 0)
            check({tag, "_frame_len"}, 32'(done_cyc[0] - rise_cyc[0]), FRAME);
        else
            check({tag, "_frame_len_missing"}, 32'(rise_cyc.size() * done_cyc.size()), 1);
        clear_mon();
    endtask

    task automatic rand_px();
        for (int i = 0; i < NL; i++) bus.rgb_flat[24*i +: 24] = 24'($urandom);
    endtask

    initial begin
        int n;
        bus.frame_req = 1'b0;
        bus.rgb_flat  = '0;
`ifdef WS_BRIGHTNESS_EN
        bus.bright = 3'd0;
`endif
        step(3);
        check("rst_ws", 32'(bus.ws), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.frame_done), 0);
        rst = 1'b0;
        step(2);
        check("idle_busy", 32'(bus.busy), 0);
        clear_mon();

        bus.rgb_flat[23:0] = 24'h008000;
        request("single");
        wait_frame("single");
        check("single_b0_hi", 32'(his[0]), T1H);
        for (int k = 1; k < 8; k++) check($sformatf("single_b%0d_hi", k), 32'(his[k]), T0H);
        check_frame("single");

        rand_px();
        bus.rgb_flat[23:0]  = 24'h0B4090;
        bus.rgb_flat[47:24] = 24'h062098;
        step(1);
        request("decode");
        wait_frame("decode");
        check_frame("decode");
        check("decode_px0_const", 32'(dec_px[0]), 32'h400B90);

        step(1);
        rand_px();
        request("snap_a");
        step(1000);
        rand_px();
        wait_frame("snap_a");
        check_frame("snap_a");
        step(1);
        request("snap_b");
        wait_frame("snap_b");
        check_frame("snap_b");

        step(1);
        rand_px();
        request("pend_a");
        for (int k = 0; k < 3; k++) begin
            step(200);
            bus.frame_req = 1'b1;
            step(1);
            bus.frame_req = 1'b0;
        end
        wait_frame("pend_a");
        check_frame("pend_a");
        step(1);
        check("pend_restart_ws", 32'(bus.ws), 1);
        check("pend_restart_busy", 32'(bus.busy), 1);
        wait_frame("pend_b");
        check_frame("pend_b");
        step(300);
        check("pend_no_dup_busy", 32'(bus.busy), 0);
        check("pend_no_dup_rise", 32'(rise_cyc.size()), 0);

        rand_px();
        request("abort");
        n = 0;
        while (bits.size() < 50 && n < FRAME) begin
            step(1);
            n++;
        end
        check("abort_reached_bit50", 32'(bits.size() >= 50), 1);
        rst = 1'b1;
        step(1);
        check("abort_ws", 32'(bus.ws), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.frame_done), 0);
        rst = 1'b0;
        step(3);
        check("abort_stays_idle", 32'(bus.busy), 0);
        clear_mon();
        rand_px();
        request("post_rst");
        wait_frame("post_rst");
        check_frame("post_rst");

`ifdef WS_BRIGHTNESS_EN
        step(1);
        bus.rgb_flat       = '0;
        bus.rgb_flat[23:0] = 24'hA000A0;
        bus.bright         = 3'd2;
        request("bright");
        bus.bright = 3'd0;
        wait_frame("bright");
        check_frame("bright");
        check("bright_px0_const", 32'(dec_px[0]), 32'h002828);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
